// File: rtl/stream_serializer_if.sv
// Stream bundle for stream_serializer: wide input word stream plus narrow
// output beat stream. Signal names keep the serializer's point of view
// (i_* flows into the serializer, o_* flows out of it).
//   slave  : the serializer itself
//   master : the surrounding logic (upstream producer + downstream consumer)
interface stream_serializer_if #(
    parameter int unsigned DLEN  = 8,
    parameter int unsigned RATIO = 4
);
    // Wide input word handshake
    logic                    i_valid;
    logic                    o_ready;
    logic [DLEN*RATIO-1:0]   i_data;
    logic                    i_last;

    // Narrow output beat handshake
    logic                    o_valid;
    logic                    i_ready;
    logic [DLEN-1:0]         o_data;
    logic                    o_last;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_last,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_last
    );

    modport master (
        output i_valid,
        output i_data,
        output i_last,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_last
    );
endinterface

// File: rtl/stream_serializer.sv
// stream_serializer: accepts one DLEN*RATIO-bit word per handshake and emits
// it as RATIO DLEN-bit beats, LSB beat first. A word's frame-end flag is
// presented on its final beat only. A new word may be accepted in the same
// cycle the previous word's final beat is taken, so a always-ready consumer
// sees back-to-back beats with no bubbles.
//
// Optional build macro:
//   STREAM_SERIALIZER_MSB_FIRST_EN - emit the most significant beat first.
//   Handshake timing is unchanged.
//
// RATIO must be >= 2.
module stream_serializer #(
    parameter int unsigned DLEN  = 8,
    parameter int unsigned RATIO = 4
) (
    input logic                clk,
    input logic                rstn,
    stream_serializer_if.slave bus
);

    localparam int unsigned WLEN = DLEN * RATIO;
    localparam int unsigned CntW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

    // State
    logic              busy_q, busy_d;
    logic [CntW-1:0]   cnt_q,  cnt_d;
    logic [WLEN-1:0]   wbuf_q, wbuf_d;
    logic              lbuf_q, lbuf_d;

    // Handshakes and decode
    logic              ihs;
    logic              ohs;
    logic              last_beat;
    logic              ready;
    logic [CntW-1:0]   beat_sel;
    logic [DLEN-1:0]   beat_data;

    assign last_beat = busy_q & (cnt_q == CntMax);

    // Ready whenever idle, or when the word in flight is leaving this cycle.
    assign ready = ~busy_q | (last_beat & bus.i_ready);

    assign ihs = bus.i_valid & ready;
    assign ohs = busy_q & bus.i_ready;

    // Beat order: map beat counter to a slice index of the word buffer.
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    assign beat_sel = CntMax - cnt_q;
`else
    assign beat_sel = cnt_q;
`endif

    // Select the current beat out of the word buffer.
    always_comb begin
        beat_data = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (beat_sel == CntW'(k)) begin
                beat_data = wbuf_q[k*DLEN +: DLEN];
            end
        end
    end

    // Next-state: load on input handshake, advance or retire on output handshake.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        wbuf_d = wbuf_q;
        lbuf_d = lbuf_q;
        if (ihs) begin
            // Covers both the idle load and the overlap with the final beat.
            busy_d = 1'b1;
            cnt_d  = '0;
            wbuf_d = bus.i_data;
            lbuf_d = bus.i_last;
        end else if (ohs) begin
            if (last_beat) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset drops any partially emitted word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            wbuf_q <= '0;
            lbuf_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            wbuf_q <= wbuf_d;
            lbuf_q <= lbuf_d;
        end
    end

    // Outputs: beat data and last are forced to zero while idle.
    always_comb begin
        bus.o_ready = ready;
        bus.o_valid = busy_q;
        bus.o_data  = busy_q ? beat_data : '0;
        bus.o_last  = last_beat & lbuf_q;
    end

    // Structural invariants of the beat counter and the stall rule.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn) cnt_q <= CntMax);

    a_idle_cnt_zero: assert property (@(posedge clk) disable iff (!rstn)
        !busy_q |-> (cnt_q == '0));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rstn)
        (bus.o_valid && !bus.i_ready) |=>
            (bus.o_valid && $stable(bus.o_data) && $stable(bus.o_last)));

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer (DLEN=8, RATIO=4). Expected beats are
// queued when a word handshake is seen and compared on every valid output
// cycle; the front entry is only retired when the consumer accepts it.
module tb_stream_serializer;

    localparam int unsigned DLEN  = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned WLEN  = DLEN * RATIO;

    typedef struct packed {
        logic [DLEN-1:0] data;
        logic            last;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    stream_serializer_if #(.DLEN(DLEN), .RATIO(RATIO)) bus ();

    stream_serializer #(
        .DLEN  (DLEN),
        .RATIO (RATIO)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    beat_t       exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_beats  = 0;
    int          waits;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected beat sequence of one word.
    function automatic void push_word(input logic [WLEN-1:0] w, input logic last);
        beat_t b;
        int unsigned idx;
        for (int unsigned k = 0; k < RATIO; k++) begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
            idx = RATIO - 1 - k;
`else
            idx = k;
`endif
            b.data = w[idx*DLEN +: DLEN];
            b.last = last && (k == RATIO - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Present a word and wait (bounded) for o_ready; returns cycles waited.
    // Leaves i_valid asserted, returns just after the accepting edge.
    task automatic send_word(input logic [WLEN-1:0] w, input logic last, output int n_wait);
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        bus.i_last  = last;
        n_wait = 0;
        do begin
            @(negedge clk);
            n_wait++;
        end while (!bus.o_ready && n_wait < 100);
        if (!bus.o_ready) check_eq("accept timeout", 0, 1);
        else push_word(w, last);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.o_valid) && t < 60) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check_eq("drained", (exp_q.size() == 0) && !bus.o_valid, 1);
    endtask

    // Output monitor: every valid cycle must match the scoreboard front.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected beat", 1, 0);
                end else begin
                    check_eq("o_data", bus.o_data, exp_q[0].data);
                    check_eq("o_last", bus.o_last, exp_q[0].last);
                    if (bus.i_ready) void'(exp_q.pop_front());
                end
                if (bus.i_ready) n_beats++;
            end else begin
                check_eq("idle o_data", bus.o_data, 0);
                check_eq("idle o_last", bus.o_last, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst o_valid", bus.o_valid, 0);
        check_eq("rst o_ready", bus.o_ready, 1);
        check_eq("rst o_data",  bus.o_data,  0);
        check_eq("rst o_last",  bus.o_last,  0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single word, consumer always ready: beats in N+1..N+4
        n_beats = 0;
        send_word(32'hDDCCBBAA, 1'b0, waits);
        check_eq("t1 accept wait", waits, 1);
        bus.i_valid = 1'b0;
        bus.i_data  = $urandom;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_eq("t1 o_valid", bus.o_valid, 1);
            check_eq("t1 o_ready", bus.o_ready, (i == 4) ? 1 : 0);
        end
        @(negedge clk);
        check_eq("t1 done o_valid", bus.o_valid, 0);
        check_eq("t1 beats", n_beats, 4);
        @(posedge clk);
        #1;

        // Back-to-back words, no bubbles
        n_beats = 0;
        send_word(32'h44332211, 1'b0, waits);
        check_eq("t2 first wait", waits, 1);
        send_word(32'h88776655, 1'b1, waits);
        check_eq("t2 second wait", waits, 4);
        bus.i_valid = 1'b0;
        bus.i_data  = $urandom;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_eq("t2 no gap", bus.o_valid, 1);
        end
        @(negedge clk);
        check_eq("t2 done o_valid", bus.o_valid, 0);
        check_eq("t2 beats", n_beats, 8);
        @(posedge clk);
        #1;

        // Frame-end word with consumer toggling ready
        n_beats = 0;
        send_word(32'hDDCCBBAA, 1'b1, waits);
        bus.i_valid = 1'b0;
        bus.i_data  = $urandom;
        for (int k = 0; k < 8; k++) begin
            bus.i_ready = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        bus.i_ready = 1'b1;
        drain();
        check_eq("t3 beats", n_beats, 4);
        @(posedge clk);
        #1;

        // Long stall: second word must not be captured
        n_beats = 0;
        bus.i_ready = 1'b0;
        send_word(32'hDDCCBBAA, 1'b0, waits);
        bus.i_data  = 32'h12345678;
        bus.i_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t4 o_valid", bus.o_valid, 1);
            check_eq("t4 o_ready", bus.o_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        drain();
        check_eq("t4 beats", n_beats, 4);
        @(posedge clk);
        #1;

        // Asynchronous reset after two beats
        send_word(32'hDDCCBBAA, 1'b1, waits);
        bus.i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("t5 rst o_valid", bus.o_valid, 0);
        check_eq("t5 rst o_ready", bus.o_ready, 1);
        check_eq("t5 rst o_data",  bus.o_data,  0);
        exp_q.delete();
        @(negedge clk);
        #2 rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t5 post o_valid", bus.o_valid, 0);
        end
        @(posedge clk);
        #1;
        n_beats = 0;
        send_word(32'h0F1E2D3C, 1'b1, waits);
        check_eq("t5 accept wait", waits, 1);
        bus.i_valid = 1'b0;
        drain();
        check_eq("t5 beats", n_beats, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
